// File: rtl/conv_pad_sequencer.sv
// Frame sequencer for one conv2d filter bank: steps the channel FIFOs in lock-step,
// wraps the frame in a one-pixel zero border and counts the bank's outputs.
module conv_pad_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CHANNELS   = 16,
    parameter int WIDTH      = 56,
    parameter int HEIGHT     = 56
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CHANNELS-1:0]            fifo_empty,
    input  logic [CHANNELS*DATA_WIDTH-1:0] fifo_data,
    output logic                           fifo_rdreq,
    input  logic                           fm_rdreq,
    input  logic                           fm_valid_out,
    output logic                           pad_empty,
    output logic [CHANNELS*DATA_WIDTH-1:0] pad_data,
    output logic                           busy,
    output logic                           done
);

    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int ROW_W = $clog2(HEIGHT + 2);
    localparam int COL_W = $clog2(WIDTH + 2);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [CNT_W-1:0] out_cnt;

    logic             in_stream;
    logic             border;
    logic             transfer;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_next;

    // The upstream FIFOs are show-ahead, so the read strobe must be combinational with the transfer.
    always_comb begin
        in_stream  = (state == STREAM);
        border     = (row == '0) || (row == ROW_LAST) || (col == '0) || (col == COL_LAST);
        pad_empty  = !in_stream || (!border && (|fifo_empty));
        pad_data   = (in_stream && !border) ? fifo_data : '0;
        transfer   = in_stream && fm_rdreq && !pad_empty;
        fifo_rdreq = transfer && !border;
    end

    always_comb begin
        cnt_en   = fm_valid_out && ((state == STREAM) || (state == DRAIN)) && (out_cnt != CNT_FULL);
        cnt_next = cnt_en ? out_cnt + 1'b1 : out_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            row     <= '0;
            col     <= '0;
            out_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= STREAM;
                        busy    <= 1'b1;
                        row     <= '0;
                        col     <= '0;
                        out_cnt <= '0;
                    end
                end
                STREAM: begin
                    out_cnt <= cnt_next;
                    if (transfer) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            if (row == ROW_LAST) begin
                                row   <= '0;
                                state <= DRAIN;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                // The final output pulse may itself complete the count.
                DRAIN: begin
                    out_cnt <= cnt_next;
                    if (cnt_next == CNT_FULL) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    out_cnt <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_pad_sequencer.sv
// Directed bench for conv_pad_sequencer: small 4x3x2 instance plus a default-size instance.
module tb_conv_pad_sequencer;

    localparam int DW = 32;
    localparam int C  = 2;
    localparam int W  = 4;
    localparam int H  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [C-1:0]    fifo_empty = '0;
    logic [C*DW-1:0] fifo_data;
    logic            fifo_rdreq;
    logic            fm_rdreq = 1'b0;
    logic            fm_valid_out = 1'b0;
    logic            pad_empty;
    logic [C*DW-1:0] pad_data;
    logic            busy;
    logic            done;

    logic            b_start = 1'b0;
    logic [15:0]     b_empty = '0;
    logic [511:0]    b_data = '0;
    logic            b_rdreq;
    logic            b_fm_rdreq = 1'b0;
    logic            b_valid = 1'b0;
    logic            b_pad_empty;
    logic [511:0]    b_pad_data;
    logic            b_busy;
    logic            b_done;

    int n_checks = 0;
    int n_errors = 0;
    int m_state = 0, m_row = 0, m_col = 0, m_cnt = 0;
    int head = 0, n_xfer = 0, n_rd = 0;
    logic [C*DW-1:0] noise = '0;
    logic [C*DW-1:0] xfer_log [64];

    always #5 clk = ~clk;

    function automatic logic [C*DW-1:0] head_word(input int h);
        return {32'(h) + 32'h200, 32'(h) + 32'h100};
    endfunction

    assign fifo_data = head_word(head) ^ noise;

    conv_pad_sequencer #(.DATA_WIDTH(DW), .CHANNELS(C), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rdreq(fifo_rdreq), .fm_rdreq(fm_rdreq), .fm_valid_out(fm_valid_out),
        .pad_empty(pad_empty), .pad_data(pad_data), .busy(busy), .done(done)
    );

    conv_pad_sequencer dut_big (
        .clk(clk), .rst(rst), .start(b_start), .fifo_empty(b_empty), .fifo_data(b_data),
        .fifo_rdreq(b_rdreq), .fm_rdreq(b_fm_rdreq), .fm_valid_out(b_valid),
        .pad_empty(b_pad_empty), .pad_data(b_pad_data), .busy(b_busy), .done(b_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the small instance: predict, compare, clock, advance the reference model.
    task automatic small_cycle(input string tag);
        logic bdr, e_pe, e_rd, e_x;
        logic [C*DW-1:0] e_data;
        bdr    = (m_row == 0) || (m_row == H + 1) || (m_col == 0) || (m_col == W + 1);
        e_pe   = 1'b1;
        e_data = '0;
        if (m_state == 1) begin
            e_pe   = bdr ? 1'b0 : (|fifo_empty);
            e_data = bdr ? '0 : head_word(head);
        end
        e_x  = (m_state == 1) && fm_rdreq && !e_pe;
        e_rd = e_x && !bdr;
        #1;
        check({tag, "_pad_empty"}, 64'(pad_empty), 64'(e_pe));
        check({tag, "_rdreq"}, 64'(fifo_rdreq), 64'(e_rd));
        check({tag, "_pad_data"}, 64'(pad_data), 64'(e_data));
        check({tag, "_busy"}, 64'(busy), 64'((m_state == 1) || (m_state == 2)));
        check({tag, "_done"}, 64'(done), 64'(m_state == 3));
        if (e_x) xfer_log[n_xfer] = pad_data;
        @(posedge clk);
        #1;
        case (m_state)
            0: if (start) begin m_state = 1; m_row = 0; m_col = 0; m_cnt = 0; end
            1: begin
                if (fm_valid_out) m_cnt++;
                if (e_x) begin
                    n_xfer++;
                    if (m_col == W + 1) begin
                        m_col = 0;
                        if (m_row == H + 1) begin m_row = 0; m_state = 2; end
                        else m_row++;
                    end else m_col++;
                end
            end
            2: begin
                if (fm_valid_out && m_cnt < W * H) m_cnt++;
                if (m_cnt == W * H) m_state = 3;
            end
            default: begin m_state = 0; m_cnt = 0; end
        endcase
        if (e_rd) begin n_rd++; head++; end
    endtask

    initial begin
        int stall, bp, bx, brd, bv;
        logic stall_seen, bp_seen;

        // Reset held with random activity on every input.
        for (int i = 0; i < 4; i++) begin
            start        = 1'($urandom);
            fifo_empty   = C'($urandom);
            fm_rdreq     = 1'($urandom);
            fm_valid_out = 1'($urandom);
            noise        = {$urandom, $urandom};
            #1;
            check("rst_pad_empty", 64'(pad_empty), 64'd1);
            check("rst_rdreq", 64'(fifo_rdreq), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_done", 64'(done), 64'd0);
            check("rst_pad_data", 64'(pad_data), 64'd0);
            @(posedge clk);
            #1;
        end
        start = 0; fifo_empty = '0; fm_rdreq = 1; fm_valid_out = 0; noise = '0;
        rst = 1;
        small_cycle("post_rst");
        small_cycle("post_rst");

        // Frame 1: border-empty, body stall, backpressure and an ignored start.
        n_xfer = 0; n_rd = 0; stall = 0; bp = 0; stall_seen = 0; bp_seen = 0;
        start = 1;
        small_cycle("f1_start");
        for (int i = 0; i < 200 && m_state == 1; i++) begin
            fifo_empty = '0; fm_rdreq = 1; start = 0;
            if (m_row == 0 && m_col == 3) fifo_empty = 2'b10;
            if (m_row == 1 && m_col == 2 && stall < 5) begin fifo_empty = 2'b10; stall++; end
            if (m_row == 2 && m_col == 3 && bp < 4) begin fm_rdreq = 0; bp++; end
            if (m_row == 2 && m_col == 1) start = 1;
            small_cycle("f1");
            if (stall == 5 && !stall_seen) begin
                stall_seen = 1;
                check("stall_row", 64'(dut.row), 64'd1);
                check("stall_col", 64'(dut.col), 64'd2);
            end
            if (bp == 4 && !bp_seen) begin
                bp_seen = 1;
                check("bp_row", 64'(dut.row), 64'd2);
                check("bp_col", 64'(dut.col), 64'd3);
            end
        end
        start = 0;
        check("f1_xfers", 64'(n_xfer), 64'd30);
        check("f1_rdreqs", 64'(n_rd), 64'd12);
        check("f1_word6", 64'(xfer_log[6]), 64'd0);
        check("f1_word7", 64'(xfer_log[7]), 64'h0000_0200_0000_0100);
        check("f1_word29", 64'(xfer_log[29]), 64'd0);

        // Drain and completion.
        small_cycle("drain");
        check("drain_busy", 64'(busy), 64'd1);
        check("drain_pad_empty", 64'(pad_empty), 64'd1);
        fm_valid_out = 1;
        for (int i = 0; i < 11; i++) small_cycle("drain_v");
        check("drain_11_done", 64'(done), 64'd0);
        small_cycle("drain_v12");
        check("done_pulse", 64'(done), 64'd1);
        check("done_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) small_cycle("idle_v");
        check("idle_done_low", 64'(done), 64'd0);
        check("idle_cnt", 64'(dut.out_cnt), 64'd0);
        fm_valid_out = 0;

        // Frame 2: reset lands mid-frame at row 2.
        start = 1;
        small_cycle("f2_start");
        start = 0;
        for (int i = 0; i < 50 && m_row != 2; i++) small_cycle("f2");
        #2;
        rst = 0;
        #1;
        check("mid_rst_pad_empty", 64'(pad_empty), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_rdreq", 64'(fifo_rdreq), 64'd0);
        check("mid_rst_pad_data", 64'(pad_data), 64'd0);
        check("mid_rst_row", 64'(dut.row), 64'd0);
        @(posedge clk);
        #1;
        rst = 1;
        m_state = 0; m_row = 0; m_col = 0; m_cnt = 0;

        // Frame 3: clean frame after reset, bank outputs overlapping the stream.
        n_xfer = 0; n_rd = 0;
        start = 1;
        small_cycle("f3_start");
        start = 0;
        for (int i = 0; i < 100 && m_state == 1; i++) begin
            fm_valid_out = (i % 3 == 2);
            small_cycle("f3");
        end
        check("f3_xfers", 64'(n_xfer), 64'd30);
        check("f3_rdreqs", 64'(n_rd), 64'd12);
        fm_valid_out = 1;
        for (int i = 0; i < 20 && m_state == 2; i++) small_cycle("f3_drain");
        fm_valid_out = 0;
        check("f3_done", 64'(done), 64'd1);
        small_cycle("f3_end");

        // Default-size instance.
        bx = 0; brd = 0; bv = 0;
        b_fm_rdreq = 1;
        #1;
        check("big_idle_pad_empty", 64'(b_pad_empty), 64'd1);
        b_start = 1;
        @(posedge clk);
        #1;
        b_start = 0;
        for (int i = 0; i < 5000; i++) begin
            #1;
            if (b_busy && b_pad_empty) break;
            if (b_fm_rdreq && !b_pad_empty) bx++;
            if (b_rdreq) brd++;
            @(posedge clk);
            #1;
        end
        check("big_xfers", 64'(bx), 64'd3364);
        check("big_rdreqs", 64'(brd), 64'd3136);
        b_valid = 1;
        for (int i = 0; i < 4000 && !b_done; i++) begin
            @(posedge clk);
            #1;
            bv++;
        end
        b_valid = 0;
        check("big_valid_pulses", 64'(bv), 64'd3136);
        check("big_done", 64'(b_done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_pad_sequencer.md
Name: conv_pad_sequencer

Overview:
- Front-end controller for one featuremap_conv2d filter bank.
- Sequences one input frame: lock-steps the CHANNELS upstream show-ahead FIFOs and injects the 1-pixel zero border. The conv2D line buffers (width WIDTH+2) therefore receive a complete padded (WIDTH+2)x(HEIGHT+2) raster.
- Counts the bank's valid_out pulses and signals frame completion to the layer scheduler.

Parameters:
- DATA_WIDTH, 32, width of one channel sample (IEEE-754 single).
- CHANNELS, 16, number of input channels sequenced in lock-step.
- WIDTH, 56, unpadded frame width in pixels.
- HEIGHT, 56, unpadded frame height in pixels.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame.
- fifo_empty  in  CHANNELS  empty flags of the upstream channel FIFOs.
- fifo_data  in  CHANNELS*DATA_WIDTH  upstream FIFO heads; channel c is at [c*DATA_WIDTH +: DATA_WIDTH].
- fifo_rdreq  out  1  shared read strobe to all upstream FIFOs.
- fm_rdreq  in  1  rdreq from the featuremap bank.
- fm_valid_out  in  1  valid_out from the featuremap bank.
- pad_empty  out  1  fanned out to every data_fifo_emptyN of the bank.
- pad_data  out  CHANNELS*DATA_WIDTH  fanned out to data_in_channelN, using the same slicing as fifo_data.
- busy  out  1  high from start accept to done.
- done  out  1  one-cycle pulse when the frame's last output is seen.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, row=col=out_cnt=0. Output values: pad_empty=1, fifo_rdreq=0, busy=0, done=0. pad_data=0 whenever not in STREAM.
- FSM states:
  - IDLE: start=1 -> STREAM on next edge; busy=1 from that edge.
  - STREAM -> DRAIN after the transfer at row=HEIGHT+1, col=WIDTH+1.
  - DRAIN -> DONE when out_cnt reaches WIDTH*HEIGHT. This can happen in the same cycle as the final fm_valid_out.
  - DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- Padded raster: row 0..HEIGHT+1, col 0..WIDTH+1, row-major. Border position = row==0, row==HEIGHT+1, col==0 or col==WIDTH+1; all other positions are body positions.
- STREAM, border position: pad_data=0 (all channels), pad_empty=0, independent of fifo_empty.
- STREAM, body position:
  - pad_data=fifo_data.
  - pad_empty = OR of fifo_empty; any empty channel stalls all channels.
- Transfer = STREAM && fm_rdreq && !pad_empty. On a transfer, col increments. At col==WIDTH+1, col wraps to 0 and row increments.
- fifo_rdreq = transfer && body position; combinational, because the FIFOs are show-ahead. Exactly WIDTH*HEIGHT strobes per frame. fifo_rdreq is never asserted while any fifo_empty bit is 1.
- pad_empty, pad_data and fifo_rdreq are combinational from fifo_empty, fm_rdreq and the registered row/col/state. There is no added latency.
- Outside STREAM: pad_empty=1, fifo_rdreq=0, so the bank never sees data between frames.
- out_cnt: width $clog2(WIDTH*HEIGHT+1). It increments on fm_valid_out only in STREAM or DRAIN; pulses in IDLE and DONE are ignored. It clears on start accept.
- start while not IDLE is ignored; there is no restart mid-frame.
- A stall (fm_rdreq=0 or an empty channel) holds row, col and state indefinitely. There is no timeout.
- Reset mid-frame: immediate return to reset values. The upstream FIFOs are not flushed; that is the scheduler's responsibility.

Test Plan (WIDTH=4, HEIGHT=3, CHANNELS=2 unless stated):
- Reset: hold rst=0 with random inputs -> pad_empty=1, fifo_rdreq=0, busy=0, done=0, pad_data=0. Release reset with start=0 -> outputs unchanged.
- Full frame, FIFOs never empty, fm_rdreq=1 -> exactly 30 transfers.
  - First 7 pad_data words are 0 (row 0 plus row 1 col 0).
  - fifo_rdreq is high on exactly 12 cycles, never on border positions.
  - State is DRAIN after the 30th transfer.
- Stall on empty: set fifo_empty=2'b10 at row 1 col 2 for 5 cycles -> pad_empty=1, fifo_rdreq=0, row/col frozen. Set the same fifo_empty at row 0 col 3 -> transfer still occurs with pad_data=0.
- Backpressure: drop fm_rdreq for 4 cycles mid-row -> no counter advance and no fifo_rdreq; on release the stream resumes at the same col with the same data.
- Completion: issue 11 fm_valid_out pulses in DRAIN -> no done. The 12th pulse -> done=1 for one cycle, busy=0, state IDLE. Extra fm_valid_out in IDLE -> out_cnt stays 0.
- Control corners:
  - start pulsed during STREAM -> ignored.
  - rst asserted at row 2 -> next frame starts from row 0 col 0 with 30 transfers.
  - Default params (56x56x16) -> 3364 transfers, 3136 fifo_rdreq, done after 3136 valid_out pulses.
